seq_detector_param: RTL and testbench

Parametrised serial bit-pattern recogniser: a runtime-programmable successor to the fixed 3-bit "101" detector. It samples one bit per qualified clock, compares the most recent `pat_len` bits against a loaded pattern, and asserts a one-cycle Moore-style match pulse. It supports overlapping and non-overlapping detection and keeps a saturating match counter. It sits between a serial bit source and control or status logic.

---
 rtl/seq_detector_param.sv | 112 +++++++++++
 tb/tb_seq_detector_param.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern recogniser with overlap/non-overlap modes,
// registered one-cycle match pulse and a saturating match counter.
module seq_detector_param #(
  parameter int             N       = 8,
  parameter int             CNT_W   = 8,
  parameter logic [N-1:0]   RST_PAT = N'(3'b101),
  parameter int             RST_LEN = 3,
  parameter bit             RST_OVL = 1'b1,
  localparam int            LW      = $clog2(N) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             x_valid,
  input  logic             cfg_load,
  input  logic [N-1:0]     cfg_pat,
  input  logic [LW-1:0]    cfg_len,
  input  logic             cfg_ovl,
  input  logic             cnt_clr,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic [LW-1:0]    cur_len
);

  localparam logic [LW-1:0]    LEN_MAX = LW'(N);
  localparam logic [LW-1:0]    LEN_RST = LW'(RST_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // The oldest history bit is shifted out before it can ever be compared,
  // so only N-1 bits need to be stored.
  logic [N-2:0]     hist, hist_d;
  logic [LW-1:0]    fill, fill_d;
  logic [N-1:0]     pat, pat_d;
  logic [LW-1:0]    len, len_d;
  logic             ovl, ovl_d;
  logic             y_d;
  logic [CNT_W-1:0] cnt_d;

  logic [N-1:0]     h_shift;
  logic [N-1:0]     len_mask;
  logic [LW-1:0]    f_inc;
  logic [LW-1:0]    len_clamped;
  logic             hit;

  // NOTE: every combinational output gets a default first so no path leaves
  // a variable unassigned, which would infer a latch.
  always_comb begin
    h_shift = {hist, x};
    f_inc   = (fill >= LEN_MAX) ? LEN_MAX : fill + LW'(1);

    for (int i = 0; i < N; i++) begin
      len_mask[i] = (LW'(i) < len);
    end

    hit = x_valid && !cfg_load && (f_inc >= len)
          && (((h_shift ^ pat) & len_mask) == '0);

    if (cfg_len == '0)         len_clamped = LW'(1);
    else if (cfg_len > LEN_MAX) len_clamped = LEN_MAX;
    else                        len_clamped = cfg_len;

    hist_d = hist;
    fill_d = fill;
    pat_d  = pat;
    len_d  = len;
    ovl_d  = ovl;
    y_d    = 1'b0;

    if (cfg_load) begin
      pat_d  = cfg_pat;
      len_d  = len_clamped;
      ovl_d  = cfg_ovl;
      hist_d = '0;
      fill_d = '0;
    end else if (x_valid) begin
      hist_d = h_shift[N-2:0];
      // A non-overlap match restarts accumulation; stale history is masked by fill.
      fill_d = (hit && !ovl) ? '0 : f_inc;
      y_d    = hit;
    end

    cnt_d = cnt_clr ? '0 : match_cnt;
    if (hit && (cnt_d != CNT_MAX)) begin
      cnt_d = cnt_d + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist      <= '0;
      fill      <= '0;
      pat       <= RST_PAT;
      len       <= LEN_RST;
      ovl       <= RST_OVL;
      y         <= 1'b0;
      match_cnt <= '0;
    end else begin
      hist      <= hist_d;
      fill      <= fill_d;
      pat       <= pat_d;
      len       <= len_d;
      ovl       <= ovl_d;
      y         <= y_d;
      match_cnt <= cnt_d;
    end
  end

  assign cur_len = len;

endmodule

// File: tb/tb_seq_detector_param.sv
// Randomised bench for seq_detector_param: two instances (8-bit and 2-bit counters)
// share stimulus and are compared each cycle against a queue-based reference model.
module tb_seq_detector_param;

  localparam int N  = 8;
  localparam int LW = $clog2(N) + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           x, x_valid, cfg_load, cfg_ovl, cnt_clr;
  logic [N-1:0]   cfg_pat;
  logic [LW-1:0]  cfg_len;
  logic           y, y_s;
  logic [7:0]     match_cnt;
  logic [1:0]     match_cnt_s;
  logic [LW-1:0]  cur_len, cur_len_s;

  always #5 clk = ~clk;

  seq_detector_param #(.N(N), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .cnt_clr(cnt_clr),
    .y(y), .match_cnt(match_cnt), .cur_len(cur_len)
  );

  seq_detector_param #(.N(N), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .cnt_clr(cnt_clr),
    .y(y_s), .match_cnt(match_cnt_s), .cur_len(cur_len_s)
  );

  // Reference model: the bits received since the last restart, newest at the back.
  bit           q[$];
  logic [N-1:0] m_pat;
  int           m_len;
  bit           m_ovl;
  bit           m_y;
  int           m_cnt, m_cnt_s;

  int n_cmp = 0;
  int n_err = 0;
  int pulses;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pat   = N'(3'b101);
    m_len   = 3;
    m_ovl   = 1'b1;
    m_y     = 1'b0;
    m_cnt   = 0;
    m_cnt_s = 0;
  endtask

  task automatic model_edge();
    bit hit = 1'b0;
    if (cfg_load) begin
      m_len = (cfg_len == 0) ? 1 : ((int'(cfg_len) > N) ? N : int'(cfg_len));
      m_pat = cfg_pat;
      m_ovl = cfg_ovl;
      q.delete();
    end else if (x_valid) begin
      q.push_back(x);
      if (q.size() > N) void'(q.pop_front());
      if (q.size() >= m_len) begin
        hit = 1'b1;
        for (int j = 0; j < m_len; j++)
          if (q[q.size() - 1 - j] != m_pat[j]) hit = 1'b0;
      end
      if (hit && !m_ovl) q.delete();
    end
    m_y = hit;
    if (cnt_clr) begin
      m_cnt   = 0;
      m_cnt_s = 0;
    end
    if (hit) begin
      if (m_cnt < 255) m_cnt++;
      if (m_cnt_s < 3) m_cnt_s++;
    end
  endtask

  task automatic compare_all();
    check("y", y, m_y);
    check("y_s", y_s, m_y);
    check("match_cnt", match_cnt, m_cnt);
    check("match_cnt_s", match_cnt_s, m_cnt_s);
    check("cur_len", cur_len, m_len);
    check("cur_len_s", cur_len_s, m_len);
  endtask

  task automatic drive(input bit xi, input bit vi, input bit ld, input logic [N-1:0] p,
                       input logic [LW-1:0] l, input bit o, input bit clr);
    x = xi; x_valid = vi; cfg_load = ld; cfg_pat = p; cfg_len = l; cfg_ovl = o; cnt_clr = clr;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    if (y === 1'b1) pulses++;
  endtask

  task automatic send(input bit xi, input bit vi);
    drive(xi, vi, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [N-1:0] p, input logic [LW-1:0] l, input bit o, input bit clr);
    drive(1'b0, 1'b0, 1'b1, p, l, o, clr);
  endtask

  initial begin
    logic [N-1:0] p8;
    rst = 1'b1;
    x = 0; x_valid = 0; cfg_load = 0; cfg_pat = '0; cfg_len = '0; cfg_ovl = 0; cnt_clr = 0;
    #12 rst = 1'b0;
    model_reset();
    #1;
    check("rst_y", y, 0);
    check("rst_cnt", match_cnt, 0);
    check("rst_len", cur_len, 3);

    // Default overlap "101": pulses after 3rd and 5th samples.
    pulses = 0;
    send(1, 1); send(0, 1); send(1, 1); send(0, 1); send(1, 1);
    check("ovl_pulses", pulses, 2);
    check("ovl_cnt", match_cnt, 2);

    // Non-overlap "101".
    load(N'(3'b101), 3, 1'b0, 1'b1);
    pulses = 0;
    send(1, 1); send(0, 1); send(1, 1); send(0, 1); send(1, 1);
    check("novl_pulses", pulses, 1);
    check("novl_cnt", match_cnt, 1);
    send(1, 1); send(0, 1); send(1, 1);
    check("novl_cnt2", match_cnt, 2);

    // Full-length pattern with valid gaps.
    p8 = 8'b11010011;
    load(p8, 8, 1'b1, 1'b1);
    pulses = 0;
    for (int i = N - 1; i >= 0; i--) begin
      send(p8[i], 1);
      if (i == 0) check("len8_hit", y, 1);
      for (int g = $urandom_range(0, 3); g > 0; g--) send(1'($urandom), 0);
    end
    check("len8_pulses", pulses, 1);

    // Length clamping and len=1 back-to-back.
    load(N'(1), 0, 1'b1, 1'b0);
    check("len0_clamp", cur_len, 1);
    pulses = 0;
    send(1, 1); send(1, 1); send(1, 1);
    check("len1_pulses", pulses, 3);
    load(N'(1), 12, 1'b1, 1'b0);
    check("len12_clamp", cur_len, 8);

    // Counter saturation, clear-with-hit, and load colliding with a sample.
    load(N'(1), 1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) send(1, 1);
    check("sat_cnt_s", match_cnt_s, 3);
    check("sat_cnt", match_cnt, 6);
    drive(1, 1, 1'b0, '0, '0, 1'b0, 1'b1);
    check("clr_hit", match_cnt, 1);
    drive(1, 1, 1'b1, N'(3'b111), 3, 1'b1, 1'b0);
    check("ld_vs_valid_y", y, 0);
    send(1, 1); send(1, 1);
    check("ld_discard", y, 0);
    send(1, 1);
    check("ld_first_hit", y, 1);

    // Asynchronous reset between edges.
    load(N'(3'b101), 3, 1'b1, 1'b0);
    send(1, 1); send(0, 1); send(1, 1); send(0, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_y", y, 0);
    check("arst_cnt", match_cnt, 0);
    check("arst_len", cur_len, 3);
    #2 rst = 1'b0;
    model_reset();
    pulses = 0;
    send(1, 1);
    check("arst_no_hit", y, 0);
    send(1, 1); send(0, 1); send(1, 1);
    check("arst_fresh_pulses", pulses, 1);

    // Randomised phase.
    for (int i = 0; i < 3000; i++) begin
      int r = $urandom_range(0, 99);
      if (r < 3)
        drive(1'($urandom), 1'($urandom), 1'b1, N'($urandom),
              ($urandom_range(0, 3) == 0) ? LW'($urandom) : LW'($urandom_range(0, 4)),
              1'($urandom), ($urandom_range(0, 3) == 0));
      else
        drive(1'($urandom), (r < 75), 1'b0, '0, '0, 1'b0, ($urandom_range(0, 49) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
